// File: rtl/modport_counter.sv
// -----------------------------------------------------------------------------
// modport_counter
//
// Synchronous, loadable, modulo-MODULUS up/down counter with a registered
// count output. State changes happen only on the rising edge of clock. The
// priority order is reset, then load, then count. There is no count enable,
// so the counter moves every cycle in which reset and load are both low.
//
// Optional feature macro: COUNTER_TC_EN
//   When defined, the output tc is added. tc is high when the next count edge
//   wraps: (up_down=1 and count=MODULUS-1) or (up_down=0 and count=0).
//   tc is combinational from the count register and up_down only. It ignores
//   load and reset. Counting behaviour is the same in both builds.
//
// Parameters
//   WIDTH    width of data_in and count
//   MODULUS  sequence length; legal count values are 0..MODULUS-1
//
// Ports
//   clock    in   1      single system clock, rising edge
//   reset    in   1      synchronous, active-high; clears count
//   up_down  in   1      direction: 1 = up, 0 = down
//   load     in   1      synchronous parallel load of data_in
//   data_in  in   WIDTH  load value; values >= MODULUS load as 0
//   count    out  WIDTH  registered counter value
//   tc       out  1      terminal count (COUNTER_TC_EN builds only)
// -----------------------------------------------------------------------------
module modport_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count
`ifdef COUNTER_TC_EN
  ,
  output logic             tc
`endif
);

  // Constants are sized to WIDTH so that every compare and add in the
  // count path works at the width of the register.
  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO      = '0;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  // A load value outside 0..MODULUS-1 would put the register into an
  // unreachable state, so any such value loads as zero.
  logic load_legal;
  assign load_legal = (data_in <= MAX_COUNT);

  // NOTE: registered state is written with non-blocking assignments, so every
  // branch below reads the pre-edge value of count, whatever the order of the
  // statements.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= ZERO;
    end else if (load) begin
      count <= load_legal ? data_in : ZERO;
    end else if (up_down) begin
      count <= (count == MAX_COUNT) ? ZERO : count + ONE;
    end else begin
      count <= (count == ZERO) ? MAX_COUNT : count - ONE;
    end
  end

`ifdef COUNTER_TC_EN
  // tc looks ahead one count step. Because it uses the current up_down, it
  // follows a direction change at once, before the next edge.
  assign tc = up_down ? (count == MAX_COUNT) : (count == ZERO);
`endif

endmodule

// File: tb/tb_modport_counter.sv
// -----------------------------------------------------------------------------
// tb_modport_counter
//
// Self-checking bench for modport_counter. A reference model written as
// modular arithmetic tracks the expected count, and the model updates on
// every rising edge. A compare process checks count (and tc when
// COUNTER_TC_EN is defined) against the model on every falling edge. Directed
// steps from the test plan also check count against literal values, which
// pins the model itself. A randomized phase follows the directed steps.
// Inputs change 1 time unit after the falling edge, well away from the
// active edge.
// -----------------------------------------------------------------------------
module tb_modport_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 14;

  logic             clock = 1'b0;
  logic             reset;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] count;
`ifdef COUNTER_TC_EN
  logic             tc;
`endif

  int n_checks = 0;
  int n_passed = 0;

  modport_counter #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .up_down(up_down),
    .load   (load),
    .data_in(data_in),
    .count  (count)
`ifdef COUNTER_TC_EN
    ,
    .tc     (tc)
`endif
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Reference model. The count is a residue modulo MODULUS, and each rule is
  // written as plain integer arithmetic.
  // ---------------------------------------------------------------------------
  int exp_count   = 0;
  bit model_valid = 1'b0;

  always @(posedge clock) begin
    if (reset === 1'b1) begin
      exp_count   <= 0;
      model_valid <= 1'b1;
    end else if (load === 1'b1) begin
      exp_count <= (int'(data_in) < MODULUS) ? int'(data_in) : 0;
    end else if (up_down === 1'b1) begin
      exp_count <= (exp_count + 1) % MODULUS;
    end else begin
      exp_count <= (exp_count + MODULUS - 1) % MODULUS;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual === expected) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: once the model has seen a reset, the DUT must match it
  // on every cycle.
  always @(negedge clock) begin
    if (model_valid) begin
      if ($isunknown(count)) check("count_known", -1, exp_count);
      else                   check("model_count", int'(count), exp_count);
`ifdef COUNTER_TC_EN
      check("model_tc", int'(tc),
            int'((up_down && exp_count == MODULUS - 1) || (!up_down && exp_count == 0)));
`endif
    end
  end

  // Apply one cycle of inputs. The task returns just after the falling edge
  // that follows the sampling edge, so count reflects these inputs.
  task automatic step(input bit r, input bit l, input bit u, input int d);
    reset   = r;
    load    = l;
    up_down = u;
    data_in = WIDTH'(d);
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic step_check(input bit r, input bit l, input bit u, input int d,
                            input string name, input int expected);
    step(r, l, u, d);
    check(name, int'(count), expected);
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b1;
    up_down = 1'b1;
    data_in = 4'd7;
    @(negedge clock);
    #1;

    // Reset for two edges while a load of 7 is requested. Reset wins.
    step_check(1, 1, 1, 7, "reset_edge1", 0);
    step_check(1, 1, 1, 7, "reset_edge2", 0);
    step_check(0, 0, 1, 0, "post_reset_up1", 1);
    step_check(0, 0, 1, 0, "post_reset_up2", 2);
    step_check(0, 0, 1, 0, "post_reset_up3", 3);

    // Up wrap 13 -> 0.
    step_check(0, 1, 1, 12, "load12", 12);
    step_check(0, 0, 1, 0,  "up_13", 13);
    step_check(0, 0, 1, 0,  "up_wrap_0", 0);
    step_check(0, 0, 1, 0,  "up_1", 1);

    // Down wrap 0 -> 13.
    step_check(0, 1, 0, 1, "load1", 1);
    step_check(0, 0, 0, 0, "down_0", 0);
    step_check(0, 0, 0, 0, "down_wrap_13", 13);
    step_check(0, 0, 0, 0, "down_12", 12);

    // Illegal load values map to 0.
    step_check(0, 1, 1, 15, "load15_to_0", 0);
    step_check(0, 1, 1, 5,  "load5", 5);
    step_check(0, 1, 1, 14, "load14_to_0", 0);

    // Count up to 5, reverse direction, then reset during a load.
    for (int i = 1; i <= 5; i++) step_check(0, 0, 1, 0, "count_to_5", i);
    step_check(0, 0, 0, 0, "reverse_to_4", 4);
    step_check(1, 1, 0, 9, "reset_over_load9", 0);

`ifdef COUNTER_TC_EN
    step_check(0, 1, 1, 13, "tc_load13_up", 13);
    check("tc_13_up", int'(tc), 1);
    step_check(0, 1, 0, 13, "tc_load13_down", 13);
    check("tc_13_down", int'(tc), 0);
    step_check(0, 1, 0, 0, "tc_load0_down", 0);
    check("tc_0_down", int'(tc), 1);
`endif

    // Randomized phase. The compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(15) == 0), ($urandom_range(3) == 0),
           1'($urandom_range(1)), int'($urandom_range(15)));
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
